// File: rtl/matrix_display_sequencer_if.sv
// Storage-query and displayer-handshake bundle driven by matrix_display_sequencer.
interface matrix_display_sequencer_if #(
  parameter int IDX_W = 3,
  parameter int CNT_W = 4
);
  logic [2:0]       req_row;
  logic [2:0]       req_col;
  logic [IDX_W-1:0] req_idx;
  logic [CNT_W-1:0] scale_cnt;
  logic             disp_start;
  logic             disp_busy;

  modport master (
    output req_row, req_col, req_idx, disp_start,
    input  scale_cnt, disp_busy
  );

  modport slave (
    input  req_row, req_col, req_idx, disp_start,
    output scale_cnt, disp_busy
  );
endinterface

// File: rtl/matrix_display_sequencer.sv
// Walks stored matrices (one scale or all scales) and hands each to the UART
// matrix displayer through a start/busy handshake, with gap, ack timeout and abort.
module matrix_display_sequencer #(
  parameter int MAX_SIZE            = 5,
  parameter int MAX_MATRIX_PER_SIZE = 4,
  parameter int IDX_W               = 3,
  parameter int CNT_W               = 4,
  parameter int GAP_CYCLES          = 16,
  parameter int ACK_TIMEOUT         = 255
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  input  logic                              abort,
  input  logic                              mode,
  input  logic [2:0]                        sel_row,
  input  logic [2:0]                        sel_col,
  matrix_display_sequencer_if.master        bus,
  output logic                              busy,
  output logic                              done,
  output logic                              aborted,
  output logic [7:0]                        shown_cnt,
  output logic                              timeout_err
);

  localparam int TMR_W = 16;
  localparam logic [TMR_W-1:0] ACK_LAST = (ACK_TIMEOUT > 0) ? TMR_W'(ACK_TIMEOUT - 1) : '0;
  localparam logic [TMR_W-1:0] GAP_LAST = (GAP_CYCLES  > 0) ? TMR_W'(GAP_CYCLES  - 1) : '0;

  typedef enum logic [3:0] {
    IDLE, LOAD, CHECK, ISSUE, WAIT_ACK, WAIT_DONE, GAP, NEXT_SCALE, FINISH
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       row_q, col_q;
  logic [IDX_W-1:0] idx_q;
  logic [CNT_W-1:0] total_q;
  logic             total_vld_q;
  logic             mode_q;
  logic [TMR_W-1:0] timer_q;

  logic             sel_ok, last_scale, idx_lt;
  logic [CNT_W-1:0] cnt_clamped, total_now;

  // control strobes from the next-state logic into the datapath
  logic accept, snap, cnt_inc, tmr_clr, tmr_inc, idx_inc, scale_adv;
  logic set_to, set_ab, matrix_end, disp_start_c;

  assign sel_ok = (sel_row != 3'd0) && (int'(sel_row) <= MAX_SIZE) &&
                  (sel_col != 3'd0) && (int'(sel_col) <= MAX_SIZE);
  assign last_scale  = (int'(row_q) == MAX_SIZE) && (int'(col_q) == MAX_SIZE);
  assign cnt_clamped = (int'(bus.scale_cnt) > MAX_MATRIX_PER_SIZE) ?
                       CNT_W'(MAX_MATRIX_PER_SIZE) : bus.scale_cnt;
  // the count is frozen at the first CHECK of a scale; later CHECKs reuse it
  assign total_now = total_vld_q ? total_q : cnt_clamped;
  assign idx_lt    = int'(idx_q) < int'(total_now);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    disp_start_c = 1'b0;
    accept       = 1'b0;
    snap         = 1'b0;
    cnt_inc      = 1'b0;
    tmr_clr      = 1'b0;
    tmr_inc      = 1'b0;
    idx_inc      = 1'b0;
    scale_adv    = 1'b0;
    set_to       = 1'b0;
    set_ab       = 1'b0;
    matrix_end   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = (mode || sel_ok) ? LOAD : FINISH;
        end
      end
      LOAD:  state_d = CHECK;
      CHECK: begin
        snap = !total_vld_q;
        if (idx_lt)      state_d = ISSUE;
        else if (mode_q) state_d = NEXT_SCALE;
        else             state_d = FINISH;
      end
      ISSUE: begin
        disp_start_c = 1'b1;
        cnt_inc      = 1'b1;
        tmr_clr      = 1'b1;
        state_d      = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (bus.disp_busy) begin
          state_d = WAIT_DONE;
        end else if (timer_q == ACK_LAST) begin
          set_to     = 1'b1;
          matrix_end = 1'b1;
        end else begin
          tmr_inc = 1'b1;
        end
      end
      WAIT_DONE: if (!bus.disp_busy) matrix_end = 1'b1;
      GAP: begin
        if (timer_q == GAP_LAST) begin
          idx_inc = 1'b1;
          state_d = CHECK;
        end else begin
          tmr_inc = 1'b1;
        end
      end
      NEXT_SCALE: begin
        if (last_scale) begin
          state_d = FINISH;
        end else begin
          scale_adv = 1'b1;
          state_d   = LOAD;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // a zero-length gap skips the GAP state entirely
    if (matrix_end) begin
      if (GAP_CYCLES == 0) begin
        idx_inc = 1'b1;
        state_d = CHECK;
      end else begin
        tmr_clr = 1'b1;
        state_d = GAP;
      end
    end

    if (abort && (state_q != IDLE) && (state_q != FINISH)) begin
      state_d      = FINISH;
      set_ab       = 1'b1;
      disp_start_c = 1'b0;
      cnt_inc      = 1'b0;
      set_to       = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q       <= '0;
      col_q       <= '0;
      idx_q       <= '0;
      total_q     <= '0;
      total_vld_q <= 1'b0;
      mode_q      <= 1'b0;
      timer_q     <= '0;
      shown_cnt   <= '0;
      timeout_err <= 1'b0;
      aborted     <= 1'b0;
    end else begin
      if (accept) begin
        mode_q      <= mode;
        shown_cnt   <= '0;
        timeout_err <= 1'b0;
        aborted     <= 1'b0;
        idx_q       <= '0;
        total_vld_q <= 1'b0;
        if (mode) begin
          row_q <= 3'd1;
          col_q <= 3'd1;
        end else if (sel_ok) begin
          row_q <= sel_row;
          col_q <= sel_col;
        end
      end
      if (scale_adv) begin
        idx_q       <= '0;
        total_vld_q <= 1'b0;
        if (int'(col_q) == MAX_SIZE) begin
          col_q <= 3'd1;
          row_q <= row_q + 3'd1;
        end else begin
          col_q <= col_q + 3'd1;
        end
      end
      if (snap) begin
        total_q     <= cnt_clamped;
        total_vld_q <= 1'b1;
      end
      if (idx_inc)                      idx_q     <= idx_q + 1'b1;
      if (cnt_inc && shown_cnt != '1)   shown_cnt <= shown_cnt + 8'd1;
      if (tmr_clr)                      timer_q   <= '0;
      else if (tmr_inc)                 timer_q   <= timer_q + 1'b1;
      if (set_to)                       timeout_err <= 1'b1;
      if (set_ab)                       aborted     <= 1'b1;
    end
  end

  assign bus.req_row    = row_q;
  assign bus.req_col    = col_q;
  assign bus.req_idx    = idx_q;
  assign bus.disp_start = disp_start_c;
  assign busy           = (state_q != IDLE);
  assign done           = (state_q == FINISH);

endmodule
